// File: rtl/mcu_sequencer_ctrl.sv
// mcu_sequencer_ctrl
// Sequencer for the 12-bit-family microcontroller. It owns the
// IDLE/LOAD/FETCH/DECODE/EXECUTE/HALT state register and the program-load
// address counter, and it decodes every datapath enable.
// Instruction fields are taken from the MSB end, so wider instruction words
// keep the same opcode layout.
// Optional build macro: MCU_SEQ_SINGLE_STEP_EN. When it is defined, a Step
// input is added and every EXECUTE->FETCH transition waits in state 6 for a
// Step pulse.
module mcu_sequencer_ctrl #(
    parameter int INSTR_W    = 12,
    parameter int PADDR_W    = 8,
    parameter int PROG_DEPTH = 256,
    parameter int MODE_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
`ifdef MCU_SEQ_SINGLE_STEP_EN
    input  logic               Step,
`endif
    input  logic               Start,
    input  logic               Resume,
    input  logic               Load_Valid,
    input  logic               DMem_Ready,
    input  logic [INSTR_W-1:0] Instr_Reg,
    input  logic [3:0]         Status_Reg,
    output logic [2:0]         State,
    output logic [PADDR_W-1:0] Load_Addr,
    output logic               ProgMemLoad_En,
    output logic               ProgMem_En,
    output logic               InstrReg_En,
    output logic               ProgCounter_En,
    output logic               Acc_En,
    output logic               StatusReg_En,
    output logic               ALU_En,
    output logic               DataMem_En,
    output logic               DataMemWrite_En,
    output logic               DataReg_En,
    output logic               MUX1_Sel,
    output logic               MUX2_Sel,
    output logic [MODE_W-1:0]  ALU_Mode
);

    localparam int T = INSTR_W - 1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_FETCH   = 3'd2;
    localparam logic [2:0] ST_DECODE  = 3'd3;
    localparam logic [2:0] ST_EXECUTE = 3'd4;
    localparam logic [2:0] ST_HALT    = 3'd5;
`ifdef MCU_SEQ_SINGLE_STEP_EN
    localparam logic [2:0] ST_STEP    = 3'd6;
    // Completed instructions park in the step-wait state.
    localparam logic [2:0] ST_AFTER_EXEC = ST_STEP;
`else
    localparam logic [2:0] ST_AFTER_EXEC = ST_FETCH;
`endif

    // Address of the final program word; that beat ends LOAD.
    localparam logic [PADDR_W-1:0] LAST_ADDR = PADDR_W'(PROG_DEPTH - 1);

    logic [2:0]         stateReg;
    logic [2:0]         stateNext;
    logic [PADDR_W-1:0] loadAddrReg;
    logic [PADDR_W-1:0] loadAddrNext;

    // Opcode class decode, evaluated in priority order in EXECUTE.
    logic       isIType;
    logic       isJump;
    logic       isMType;
    logic       isNop;
    logic       mToAcc;
    logic [1:0] jumpSel;
    logic       jumpFlag;

    logic [MODE_W-1:0] iTypeMode;
    logic [MODE_W-1:0] mTypeMode;

    // Bits of the instruction word that no field uses (operand/address bits).
    logic unusedIrBits;

    assign isIType  = Instr_Reg[T];
    assign isJump   = (Instr_Reg[T:T-1] == 2'b01);
    assign isMType  = (Instr_Reg[T:T-2] == 3'b001);
    assign isNop    = (Instr_Reg[T:T-3] == 4'b0000);
    assign mToAcc   = Instr_Reg[T-3];
    assign jumpSel  = Instr_Reg[T-2:T-3];
    assign jumpFlag = Status_Reg[jumpSel];
    assign unusedIrBits = ^Instr_Reg;

    // ALU mode fields resized to MODE_W: I-type uses a 3-bit field, M-type a
    // 4-bit field; extra upper bits are zero, narrower modes keep the LSBs.
    genvar gi;
    generate
        for (gi = 0; gi < MODE_W; gi++) begin : g_mode
            if (gi < 3) begin : g_i_bit
                assign iTypeMode[gi] = Instr_Reg[T-3+gi];
            end else begin : g_i_zero
                assign iTypeMode[gi] = 1'b0;
            end
            if (gi < 4) begin : g_m_bit
                assign mTypeMode[gi] = Instr_Reg[T-7+gi];
            end else begin : g_m_zero
                assign mTypeMode[gi] = 1'b0;
            end
        end
    endgenerate

    assign State     = stateReg;
    assign Load_Addr = loadAddrReg;

    // State register and load counter; reset aborts any load or access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg    <= ST_IDLE;
            loadAddrReg <= '0;
        end else begin
            stateReg    <= stateNext;
            loadAddrReg <= loadAddrNext;
        end
    end

    // Next-state and load-address selection.
    always_comb begin
        stateNext    = stateReg;
        loadAddrNext = loadAddrReg;
        case (stateReg)
            ST_IDLE: begin
                if (Start) begin
                    stateNext = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (Load_Valid) begin
                    if (loadAddrReg == LAST_ADDR) begin
                        stateNext    = ST_FETCH;
                        loadAddrNext = '0;
                    end else begin
                        loadAddrNext = loadAddrReg + PADDR_W'(1);
                    end
                end
            end
            ST_FETCH: begin
                stateNext = ST_DECODE;
            end
            ST_DECODE: begin
                // Memory operands hold DECODE until the data read completes.
                if (!isMType || DMem_Ready) begin
                    stateNext = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (isIType || isJump || isNop) begin
                    stateNext = ST_AFTER_EXEC;
                end else if (isMType) begin
                    // Stores wait for the write to complete; loads do not.
                    if (mToAcc || DMem_Ready) begin
                        stateNext = ST_AFTER_EXEC;
                    end
                end else begin
                    stateNext = ST_HALT;
                end
            end
            ST_HALT: begin
                if (Resume) begin
                    stateNext = ST_FETCH;
                end
            end
`ifdef MCU_SEQ_SINGLE_STEP_EN
            ST_STEP: begin
                if (Step) begin
                    stateNext = ST_FETCH;
                end
            end
`endif
            default: begin
                stateNext    = ST_IDLE;
                loadAddrNext = '0;
            end
        endcase
    end

    // Datapath control decode from state, instruction, flags and ready.
    always_comb begin
        ProgMemLoad_En  = 1'b0;
        ProgMem_En      = 1'b0;
        InstrReg_En     = 1'b0;
        ProgCounter_En  = 1'b0;
        Acc_En          = 1'b0;
        StatusReg_En    = 1'b0;
        ALU_En          = 1'b0;
        DataMem_En      = 1'b0;
        DataMemWrite_En = 1'b0;
        DataReg_En      = 1'b0;
        MUX1_Sel        = 1'b0;
        MUX2_Sel        = 1'b0;
        ALU_Mode        = '0;
        case (stateReg)
            ST_LOAD: begin
                ProgMem_En     = 1'b1;
                ProgMemLoad_En = Load_Valid;
            end
            ST_FETCH: begin
                InstrReg_En = 1'b1;
                ProgMem_En  = 1'b1;
            end
            ST_DECODE: begin
                if (isMType) begin
                    DataMem_En = 1'b1;
                    DataReg_En = DMem_Ready;
                end
            end
            ST_EXECUTE: begin
                if (isIType) begin
                    ProgCounter_En = 1'b1;
                    Acc_En         = 1'b1;
                    StatusReg_En   = 1'b1;
                    ALU_En         = 1'b1;
                    MUX1_Sel       = 1'b1;
                    ALU_Mode       = iTypeMode;
                end else if (isJump) begin
                    ProgCounter_En = 1'b1;
                    MUX1_Sel       = jumpFlag;
                end else if (isMType) begin
                    ALU_En   = 1'b1;
                    MUX1_Sel = 1'b1;
                    MUX2_Sel = 1'b1;
                    ALU_Mode = mTypeMode;
                    if (mToAcc) begin
                        Acc_En         = 1'b1;
                        ProgCounter_En = 1'b1;
                        StatusReg_En   = 1'b1;
                    end else begin
                        DataMem_En      = 1'b1;
                        DataMemWrite_En = 1'b1;
                        ProgCounter_En  = DMem_Ready;
                        StatusReg_En    = DMem_Ready;
                    end
                end else if (isNop) begin
                    ProgCounter_En = 1'b1;
                    MUX1_Sel       = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mcu_sequencer_ctrl.sv
// Testbench for mcu_sequencer_ctrl (default parameters).
// Expected behaviour comes from a per-instruction trace model: for each
// instruction the bench lists the cycles it must take and the controls each
// cycle must show, derived from the opcode classes and handshake rules.
module tb_mcu_sequencer_ctrl;

    logic        clk;
    logic        rst;
    logic        Step;
    logic        Start;
    logic        Resume;
    logic        Load_Valid;
    logic        DMem_Ready;
    logic [11:0] Instr_Reg;
    logic [3:0]  Status_Reg;
    logic [2:0]  State;
    logic [7:0]  Load_Addr;
    logic        ProgMemLoad_En, ProgMem_En, InstrReg_En, ProgCounter_En;
    logic        Acc_En, StatusReg_En, ALU_En, DataMem_En, DataMemWrite_En;
    logic        DataReg_En, MUX1_Sel, MUX2_Sel;
    logic [3:0]  ALU_Mode;
    logic [11:0] ctl;

    int checks = 0;
    int errors = 0;

    localparam logic [11:0] B_PL = 12'h800, B_PM = 12'h400, B_IR = 12'h200;
    localparam logic [11:0] B_PC = 12'h100, B_AC = 12'h080, B_SR = 12'h040;
    localparam logic [11:0] B_AL = 12'h020, B_DM = 12'h010, B_DW = 12'h008;
    localparam logic [11:0] B_DR = 12'h004, B_M1 = 12'h002, B_M2 = 12'h001;

    typedef struct packed {
        logic [2:0]  st;
        logic [11:0] ctl;
        logic [3:0]  mode;
        logic        rdy;
        logic        stp;
    } exp_t;

    exp_t expQ[$];

    assign ctl = {ProgMemLoad_En, ProgMem_En, InstrReg_En, ProgCounter_En,
                  Acc_En, StatusReg_En, ALU_En, DataMem_En, DataMemWrite_En,
                  DataReg_En, MUX1_Sel, MUX2_Sel};

    mcu_sequencer_ctrl dut (
        .clk(clk),
        .rst(rst),
`ifdef MCU_SEQ_SINGLE_STEP_EN
        .Step(Step),
`endif
        .Start(Start),
        .Resume(Resume),
        .Load_Valid(Load_Valid),
        .DMem_Ready(DMem_Ready),
        .Instr_Reg(Instr_Reg),
        .Status_Reg(Status_Reg),
        .State(State),
        .Load_Addr(Load_Addr),
        .ProgMemLoad_En(ProgMemLoad_En),
        .ProgMem_En(ProgMem_En),
        .InstrReg_En(InstrReg_En),
        .ProgCounter_En(ProgCounter_En),
        .Acc_En(Acc_En),
        .StatusReg_En(StatusReg_En),
        .ALU_En(ALU_En),
        .DataMem_En(DataMem_En),
        .DataMemWrite_En(DataMemWrite_En),
        .DataReg_En(DataReg_En),
        .MUX1_Sel(MUX1_Sel),
        .MUX2_Sel(MUX2_Sel),
        .ALU_Mode(ALU_Mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "timeout");
    end

    function automatic exp_t mk(input logic [2:0] st, input logic [11:0] c,
                                input logic [3:0] m, input logic r, input logic s);
        exp_t e;
        e.st = st; e.ctl = c; e.mode = m; e.rdy = r; e.stp = s;
        return e;
    endfunction

    // Build the expected cycle trace of one instruction starting in FETCH.
    task automatic model_instr(input logic [11:0] ir, input logic [3:0] sts,
                               input int wdec, input int wexe, input int hold,
                               output logic [2:0] endSt);
        int top4;
        bit isM;
        logic [3:0]  md;
        logic [11:0] base;
        top4 = int'(ir[11:8]);
        isM  = (top4 / 2) == 1;
        md   = ir[7:4];
        base = B_AL | B_M1 | B_M2;
        expQ.delete();
        expQ.push_back(mk(3'd2, B_PM | B_IR, 4'd0, 1'($urandom), 1'b0));
        if (isM) begin
            for (int k = 0; k < wdec; k++) expQ.push_back(mk(3'd3, B_DM, 4'd0, 1'b0, 1'b0));
            expQ.push_back(mk(3'd3, B_DM | B_DR, 4'd0, 1'b1, 1'b0));
        end else begin
            expQ.push_back(mk(3'd3, 12'h000, 4'd0, 1'($urandom), 1'b0));
        end
        endSt = 3'd2;
        if (top4 >= 8) begin
            expQ.push_back(mk(3'd4, B_PC | B_AC | B_SR | B_AL | B_M1,
                              4'(int'(ir[10:8])), 1'($urandom), 1'b0));
        end else if (top4 >= 4) begin
            expQ.push_back(mk(3'd4, B_PC | (sts[ir[9:8]] ? B_M1 : 12'h000),
                              4'd0, 1'($urandom), 1'b0));
        end else if (isM) begin
            if (top4 % 2 == 1) begin
                expQ.push_back(mk(3'd4, base | B_AC | B_PC | B_SR, md, 1'($urandom), 1'b0));
            end else begin
                for (int k = 0; k < wexe; k++) expQ.push_back(mk(3'd4, base | B_DM | B_DW, md, 1'b0, 1'b0));
                expQ.push_back(mk(3'd4, base | B_DM | B_DW | B_PC | B_SR, md, 1'b1, 1'b0));
            end
        end else if (top4 == 0) begin
            expQ.push_back(mk(3'd4, B_PC | B_M1, 4'd0, 1'($urandom), 1'b0));
        end else begin
            expQ.push_back(mk(3'd4, 12'h000, 4'd0, 1'($urandom), 1'b0));
            endSt = 3'd5;
        end
`ifdef MCU_SEQ_SINGLE_STEP_EN
        if (endSt == 3'd2) begin
            for (int k = 0; k < hold; k++) expQ.push_back(mk(3'd6, 12'h000, 4'd0, 1'($urandom), 1'b0));
            expQ.push_back(mk(3'd6, 12'h000, 4'd0, 1'($urandom), 1'b1));
        end
`else
        if (hold < 0) endSt = 3'd7;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; Step = 1'b0; Start = 1'b0; Resume = 1'b0; Load_Valid = 1'b0;
        DMem_Ready = 1'b0; Instr_Reg = 12'h000; Status_Reg = 4'h0;
        #3;
        checks++;
        if (State !== 3'd0 || Load_Addr !== 8'd0 || ctl !== 12'h000 || ALU_Mode !== 4'd0) begin
            errors++;
            $display("FAIL reset_state state=%0d addr=%0d ctl=%h mode=%h required 0/0/000/0", State, Load_Addr, ctl, ALU_Mode);
        end
        // Start while reset is held must not leave IDLE.
        @(negedge clk); Start = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (State !== 3'd0) begin
            errors++;
            $display("FAIL reset_dominates_start state=%0d required 0", State);
        end
        rst = 1'b0; Start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); Resume = 1'($urandom); Load_Valid = 1'($urandom); DMem_Ready = 1'($urandom);
            #1;
            checks++;
            if (State !== 3'd0 || ctl !== 12'h000) begin
                errors++;
                $display("FAIL idle_hold state=%0d ctl=%h required 0/000", State, ctl);
            end
        end
        $display("test_reset done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_load_abort();
        @(negedge clk); Start = 1'b1; Load_Valid = 1'b1; #1;
        checks++;
        if (State !== 3'd0 || ctl !== 12'h000) begin
            errors++;
            $display("FAIL idle_start_cycle state=%0d ctl=%h required 0/000", State, ctl);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); Start = 1'b0; Load_Valid = 1'b1; #1;
            checks++;
            if (State !== 3'd1 || Load_Addr !== 8'(k)) begin
                errors++;
                $display("FAIL abort_load_beat state=%0d addr=%0d required 1/%0d", State, Load_Addr, k);
            end
        end
        @(negedge clk); #2 rst = 1'b1; #1;
        checks++;
        if (State !== 3'd0 || Load_Addr !== 8'd0 || ctl !== 12'h000) begin
            errors++;
            $display("FAIL async_reset_mid_load state=%0d addr=%0d ctl=%h required 0/0/000", State, Load_Addr, ctl);
        end
        @(negedge clk); rst = 1'b0; Load_Valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (State !== 3'd0 || Load_Addr !== 8'd0) begin
            errors++;
            $display("FAIL after_load_abort state=%0d addr=%0d required 0/0", State, Load_Addr);
        end
        $display("test_load_abort done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_load();
        int expAddr;
        int gapAt[3];
        bit gapUsed[3];
        logic lv;
        expAddr = 0;
        gapAt[0] = $urandom_range(1, 80);
        gapAt[1] = $urandom_range(81, 160);
        gapAt[2] = $urandom_range(161, 255);
        gapUsed = '{1'b0, 1'b0, 1'b0};
        @(negedge clk); Start = 1'b1; Load_Valid = 1'b0;
        while (expAddr < 256) begin
            lv = 1'b1;
            for (int j = 0; j < 3; j++) begin
                if (!gapUsed[j] && expAddr == gapAt[j]) begin
                    lv = 1'b0;
                    gapUsed[j] = 1'b1;
                end
            end
            @(negedge clk);
            Load_Valid = lv; Start = 1'($urandom); Resume = 1'($urandom); DMem_Ready = 1'($urandom);
            #1;
            checks++;
            if (State !== 3'd1 || Load_Addr !== 8'(expAddr) || ctl !== (B_PM | (lv ? B_PL : 12'h000))) begin
                errors++;
                $display("FAIL load_beat valid=%0b state=%0d addr=%0d ctl=%h required 1/%0d/%h",
                         lv, State, Load_Addr, ctl, expAddr, B_PM | (lv ? B_PL : 12'h000));
            end
            if (lv) expAddr++;
        end
        @(posedge clk); #1;
        checks++;
        if (State !== 3'd2 || Load_Addr !== 8'd0) begin
            errors++;
            $display("FAIL load_done state=%0d addr=%0d required 2/0", State, Load_Addr);
        end
        $display("test_load done gaps=%0d,%0d,%0d checks=%0d errors=%0d", gapAt[0], gapAt[1], gapAt[2], checks, errors);
    endtask

    task automatic test_instructions();
        logic [11:0] dirIr[7];
        logic [3:0]  dirSts[7];
        int          dirWdec[7];
        int          dirWexe[7];
        logic [11:0] ir;
        logic [3:0]  sts;
        int          wdec, wexe, hold;
        logic [2:0]  endSt;
        exp_t        e;
        dirIr   = '{12'hB25, 12'h5A3, 12'h5A3, 12'h2A7, 12'h000, 12'h3C1, 12'h100};
        dirSts  = '{4'h0,    4'h2,    4'h0,    4'h0,    4'h0,    4'h0,    4'h0};
        dirWdec = '{0, 0, 0, 0, 0, 2, 0};
        dirWexe = '{0, 0, 0, 4, 0, 0, 0};
        for (int n = 0; n < 37; n++) begin
            if (n < 7) begin
                ir = dirIr[n]; sts = dirSts[n]; wdec = dirWdec[n]; wexe = dirWexe[n];
                hold = (n == 0) ? 10 : 0;
            end else begin
                do ir = 12'($urandom); while (ir[11:8] == 4'b0001);
                sts = 4'($urandom); wdec = $urandom_range(0, 3); wexe = $urandom_range(0, 3);
                hold = $urandom_range(0, 2);
            end
            model_instr(ir, sts, wdec, wexe, hold, endSt);
            while (expQ.size() > 0) begin
                e = expQ.pop_front();
                @(negedge clk);
                Instr_Reg = ir; Status_Reg = sts; DMem_Ready = e.rdy;
                Start = 1'($urandom); Resume = 1'($urandom); Load_Valid = 1'($urandom);
                Step = e.stp;
                #1;
                checks++;
                if (State !== e.st || ctl !== e.ctl || ALU_Mode !== e.mode) begin
                    errors++;
                    $display("FAIL instr_cycle ir=%h sts=%h rdy=%0b state=%0d ctl=%h mode=%h required %0d/%h/%h",
                             ir, sts, e.rdy, State, ctl, ALU_Mode, e.st, e.ctl, e.mode);
                end
            end
            @(posedge clk); #1;
            checks++;
            if (State !== endSt) begin
                errors++;
                $display("FAIL instr_end ir=%h state=%0d required %0d", ir, State, endSt);
            end
            if (endSt == 3'd5) begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk); Resume = 1'b0; Start = 1'($urandom); DMem_Ready = 1'($urandom); Step = 1'b0;
                    #1;
                    checks++;
                    if (State !== 3'd5 || ctl !== 12'h000 || ALU_Mode !== 4'd0) begin
                        errors++;
                        $display("FAIL halt_hold state=%0d ctl=%h mode=%h required 5/000/0", State, ctl, ALU_Mode);
                    end
                end
                @(negedge clk); Resume = 1'b1; #1;
                @(posedge clk); #1;
                checks++;
                if (State !== 3'd2) begin
                    errors++;
                    $display("FAIL halt_resume state=%0d required 2", State);
                end
            end
            $display("instr n=%0d ir=%h sts=%h wdec=%0d wexe=%0d end=%0d checks=%0d errors=%0d",
                     n, ir, sts, wdec, wexe, endSt, checks, errors);
        end
    endtask

    task automatic test_reset_mid_decode();
        @(negedge clk);
        Instr_Reg = 12'h2A7; DMem_Ready = 1'b0; Resume = 1'b0; Start = 1'b0; Step = 1'b0;
        #1;
        checks++;
        if (State !== 3'd2) begin
            errors++;
            $display("FAIL mid_decode_fetch state=%0d required 2", State);
        end
        @(negedge clk); #1;
        @(negedge clk); #1;
        checks++;
        if (State !== 3'd3 || ctl !== B_DM) begin
            errors++;
            $display("FAIL decode_wait state=%0d ctl=%h required 3/%h", State, ctl, B_DM);
        end
        #1 rst = 1'b1; #1;
        checks++;
        if (State !== 3'd0 || Load_Addr !== 8'd0 || ctl !== 12'h000 || ALU_Mode !== 4'd0) begin
            errors++;
            $display("FAIL async_reset_mid_decode state=%0d addr=%0d ctl=%h required 0/0/000", State, Load_Addr, ctl);
        end
        @(negedge clk); rst = 1'b0; DMem_Ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (State !== 3'd0) begin
            errors++;
            $display("FAIL after_decode_reset state=%0d required 0", State);
        end
        $display("test_reset_mid_decode done checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        test_reset();
        test_load_abort();
        test_load();
        test_instructions();
        test_reset_mid_decode();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcu_sequencer_ctrl.md
Name: mcu_sequencer_ctrl

Overview:
- Parametrised successor to the 12-bit microcontroller's combinational control decode.
- Owns the LOAD/FETCH/DECODE/EXECUTE state register and a program-load address counter.
- Adds a data-memory ready handshake, explicit IDLE and HALT states, and width-generic instruction field decode.
- Sits between the program/data memories, IR, PC, accumulator, status register and ALU; drives every datapath enable.

Parameters:
- INSTR_W, 12, instruction width; must be >= 12. Fields are taken from the MSB end, with T = INSTR_W-1.
- PADDR_W, 8, program address width; also the width of Load_Addr.
- PROG_DEPTH, 256, number of words written during LOAD; must be 1 to 2^PADDR_W.
- MODE_W, 4, width of ALU_Mode.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- Start  in  1  1-cycle pulse; in IDLE, begins LOAD.
- Resume  in  1  1-cycle pulse; in HALT, returns to FETCH.
- Load_Valid  in  1  a program word is present this cycle during LOAD.
- DMem_Ready  in  1  data memory has completed its access this cycle.
- Instr_Reg  in  INSTR_W  current instruction register contents.
- Status_Reg  in  4  status flags {O,S,C,Z}, indexed 3..0.
- State  out  3  IDLE=0, LOAD=1, FETCH=2, DECODE=3, EXECUTE=4, HALT=5.
- Load_Addr  out  PADDR_W  program memory write address.
- ProgMemLoad_En, ProgMem_En, InstrReg_En, ProgCounter_En, Acc_En, StatusReg_En, ALU_En, DataMem_En, DataMemWrite_En, DataReg_En, MUX1_Sel, MUX2_Sel  out  1 each  datapath controls.
- ALU_Mode  out  MODE_W  ALU operation select.

Behaviour:
- Clocking and reset: one clock `clk`. `rst` is asynchronous and active-high.
- On reset: State=IDLE, Load_Addr=0, and every control output is 0.
- Reset mid-LOAD or mid-access aborts immediately; no partial state survives.
- Outputs: all control outputs are combinational from State, Instr_Reg, Status_Reg and DMem_Ready. Default value is 0.
- IDLE: no controls asserted. Start=1 -> LOAD at the next edge.
- LOAD: ProgMem_En=1. ProgMemLoad_En=Load_Valid.
  - Each cycle with Load_Valid=1 writes at Load_Addr, then Load_Addr increments.
  - The beat with Load_Addr=PROG_DEPTH-1 moves to FETCH and clears Load_Addr to 0.
  - Load_Valid=0 stalls with no increment. Start is ignored here.
- FETCH: InstrReg_En=1, ProgMem_En=1. Always -> DECODE.
- DECODE:
  - If Instr_Reg[T:T-2]=001 (M-type): DataMem_En=1; DataReg_En=DMem_Ready. Stay in DECODE until DMem_Ready=1, then -> EXECUTE.
  - Otherwise -> EXECUTE after 1 cycle.
- EXECUTE, decoded by priority:
  - I-type, Instr_Reg[T]=1: ProgCounter_En=1, Acc_En=1, StatusReg_En=1, ALU_En=1, MUX1_Sel=1, MUX2_Sel=0. ALU_Mode=Instr_Reg[T-1:T-3] zero-extended to MODE_W. -> FETCH.
  - Jump, Instr_Reg[T:T-1]=01: ProgCounter_En=1, MUX1_Sel=Status_Reg[Instr_Reg[T-2:T-3]]. -> FETCH.
  - M-type, with L=Instr_Reg[T-3]:
    - ALU_En=1, MUX1_Sel=1, MUX2_Sel=1, ALU_Mode=Instr_Reg[T-4:T-7] resized to MODE_W.
    - L=1 (to accumulator): Acc_En=1, ProgCounter_En=1, StatusReg_En=1. 1 cycle, then -> FETCH.
    - L=0 (store): DataMem_En=1, DataMemWrite_En=1. ProgCounter_En and StatusReg_En are asserted only in the cycle with DMem_Ready=1. Stay in EXECUTE until DMem_Ready=1, then -> FETCH.
  - NOP, Instr_Reg[T:T-3]=0000: ProgCounter_En=1, MUX1_Sel=1. -> FETCH.
  - HALT, Instr_Reg[T:T-3]=0001: no controls asserted. -> HALT.
- HALT: no controls asserted. Resume=1 -> FETCH; the PC is not advanced, so the HALT re-executes.
- Simultaneous events: rst dominates everything. Start outside IDLE and Resume outside HALT are ignored.
- Latency: 3 cycles per non-memory instruction. An M-type instruction takes 3 + (cycles waiting for DMem_Ready).
- Unused encodings: States 6 and 7 -> IDLE at the next edge, with all controls 0.

Optional Feature:
- Macro: MCU_SEQ_SINGLE_STEP_EN.
- When defined:
  - Adds input port Step (1 bit).
  - Every transition EXECUTE->FETCH goes instead to a wait state, encoded 6.
  - In the wait state all controls are 0; the block moves to FETCH on Step=1.
  - rst still clears the block to IDLE.
- When undefined: there is no Step port, encoding 6 is illegal (recovers to IDLE), and behaviour is exactly as above.

Test Plan:
- Load: rst, Start pulse, Load_Valid=1 for 256 cycles -> Load_Addr counts 0..255, ProgMemLoad_En=1 on each beat, State=FETCH on the next cycle. Insert 3 Load_Valid=0 gaps -> Load_Addr holds during each gap.
- I-type: IR=0xB25 -> FETCH, DECODE, EXECUTE with ALU_Mode=0x3, Acc_En=ProgCounter_En=StatusReg_En=ALU_En=MUX1_Sel=1, MUX2_Sel=0; back in FETCH 3 cycles later.
- Jump: IR=0x5xx with Status_Reg=4'b0010 -> MUX1_Sel=1. The same IR with Status_Reg=0 -> MUX1_Sel=0. ProgCounter_En=1 in both cases.
- M-type store: IR=0x2A7, DMem_Ready low for 4 cycles in EXECUTE -> DataMemWrite_En=1 held 5 cycles, ProgCounter_En=1 only in the final cycle, ALU_Mode=0xA.
- HALT/reset: IR=0x100 -> State=HALT with all controls 0; Resume -> FETCH. Assert rst asynchronously mid-DECODE wait -> State=IDLE and Load_Addr=0 before the next edge.
- Single step (macro defined): after EXECUTE, State=6 holds for 10 cycles; a Step pulse -> FETCH.
